hex_word_sender: RTL and testbench

- Upstream stage of the RS232 transmitter. Accepts binary words and serialises each one into ASCII hexadecimal characters, MSB nibble first, optionally followed by CR LF.
- The byte output drives the transmitter's data/valid/ready inputs directly.
- Used for debug dumps of counters and registers over the serial link.

---
 rtl/hex_word_sender_if.sv | 15 +
 rtl/hex_word_sender.sv | 96 +++++++++
 tb/tb_hex_word_sender.sv | 111 +++++++++++
 3 files changed

// File: rtl/hex_word_sender_if.sv
// hex_word_sender_if: word-in / ASCII-byte-out handshake bundle
// master: word producer + byte consumer (drives in_data/in_valid/out_ready)
// slave : hex_word_sender (drives in_ready/out_data/out_valid)
interface hex_word_sender_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/hex_word_sender.sv
// hex_word_sender: serialises binary words into ASCII hex digits (MSB nibble first), optional CR LF
// clock   : rising-edge system clock
// reset_n : synchronous active-low reset
// bus     : slave side of hex_word_sender_if (word in_*, ASCII byte out_*), all outputs registered
module hex_word_sender #(
  parameter int WORD_WIDTH = 32,
  parameter bit NEWLINE    = 1'b1,
  parameter bit UPPERCASE  = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  hex_word_sender_if.slave   bus
);
  localparam int DIGITS = WORD_WIDTH / 4;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEX  = 2'd1;
  localparam logic [1:0] S_CR   = 2'd2;
  localparam logic [1:0] S_LF   = 2'd3;
  logic [1:0]            r_state;
  logic [WORD_WIDTH-1:0] r_word;
  logic [IW-1:0]         r_idx;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [7:0]            r_out_data;
  logic                  w_out_hs;
  logic                  w_in_hs;
  logic [IW-1:0]         w_next_idx;
  logic [WORD_WIDTH-1:0] w_shift;
  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nib};
  endfunction
  assign w_out_hs   = r_out_valid && bus.out_ready;
  assign w_in_hs    = r_in_ready && bus.in_valid;
  assign w_next_idx = r_idx - 1'b1;
  // shift rather than indexed part-select keeps the select width-agnostic for any DIGITS
  assign w_shift    = r_word >> {w_next_idx, 2'b00};
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_hs) begin
            r_word      <= bus.in_data;
            r_out_data  <= to_ascii(bus.in_data[WORD_WIDTH-1 -: 4]);
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_idx       <= IW'(DIGITS - 1);
            r_state     <= S_HEX;
          end else begin
            r_in_ready  <= 1'b1;
          end
        end
        S_HEX: begin
          if (w_out_hs) begin
            if (r_idx == '0) begin
              if (NEWLINE) begin
                r_out_data  <= 8'h0D;
                r_state     <= S_CR;
              end else begin
                r_out_valid <= 1'b0;
                r_in_ready  <= 1'b1;
                r_state     <= S_IDLE;
              end
            end else begin
              r_idx      <= w_next_idx;
              r_out_data <= to_ascii(w_shift[3:0]);
            end
          end
        end
        S_CR: begin
          if (w_out_hs) begin
            r_out_data <= 8'h0A;
            r_state    <= S_LF;
          end
        end
        default: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_hex_word_sender.sv
// tb_hex_word_sender: directed self-checking bench for hex_word_sender (32-bit/CRLF/upper and 8-bit/raw/lower)
module tb_hex_word_sender;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  hex_word_sender_if #(.WORD_WIDTH(32)) a_if ();
  hex_word_sender_if #(.WORD_WIDTH(8))  b_if ();
  hex_word_sender #(.WORD_WIDTH(32), .NEWLINE(1'b1), .UPPERCASE(1'b1)) u_a (
    .clock(clk), .reset_n(rst_n), .bus(a_if.slave));
  hex_word_sender #(.WORD_WIDTH(8), .NEWLINE(1'b0), .UPPERCASE(1'b0)) u_b (
    .clock(clk), .reset_n(rst_n), .bus(b_if.slave));
  logic [7:0] seq1 [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_a(input logic [31:0] w);
    chk("a_ready_before_send", a_if.in_ready, 1);
    a_if.in_data  = w;
    a_if.in_valid = 1'b1;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    chk("a_ready_after_accept", a_if.in_ready, 0);
  endtask
  task automatic recv_a(input logic [7:0] exp, input int stall);
    for (int i = 0; i < stall; i++) begin
      a_if.out_ready = 1'b0;
      chk("a_stall_valid", a_if.out_valid, 1);
      chk("a_stall_data", a_if.out_data, exp);
      @(negedge clk);
    end
    a_if.out_ready = 1'b1;
    chk("a_char_valid", a_if.out_valid, 1);
    chk("a_char_data", a_if.out_data, exp);
    @(negedge clk);
  endtask
  task automatic idle_a();
    chk("a_idle_valid", a_if.out_valid, 0);
    chk("a_idle_ready", a_if.in_ready, 1);
  endtask
  initial begin
    rst_n = 1'b0;
    a_if.in_data = '0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_data = '0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_a_valid", a_if.out_valid, 0);
      chk("rst_a_data", a_if.out_data, 8'h00);
      chk("rst_a_ready", a_if.in_ready, 0);
      chk("rst_b_valid", b_if.out_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_a_ready", a_if.in_ready, 1);
    chk("rel_b_ready", b_if.in_ready, 1);
    a_if.out_ready = 1'b1;
    send_a(32'h1234ABCD);
    for (int i = 0; i < 10; i++) recv_a(seq1[i], 0);
    idle_a();
    send_a(32'h1234ABCD);
    for (int i = 0; i < 10; i++) recv_a(seq1[i], (i == 3) ? 20 : 1);
    idle_a();
    send_a(32'h1234ABCD);
    for (int i = 0; i < 5; i++) recv_a(seq1[i], 0);
    chk("mid_b_char", a_if.out_data, 8'h42);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", a_if.out_valid, 0);
    chk("mid_rst_data", a_if.out_data, 8'h00);
    chk("mid_rst_ready", a_if.in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send_a(32'h0);
    for (int i = 0; i < 8; i++) recv_a(8'h30, 0);
    recv_a(8'h0D, 0);
    recv_a(8'h0A, 0);
    idle_a();
    b_if.out_ready = 1'b1;
    b_if.in_data   = 8'hFE;
    b_if.in_valid  = 1'b1;
    @(negedge clk);
    chk("b_ready_busy", b_if.in_ready, 0);
    chk("b_c0_valid", b_if.out_valid, 1);
    chk("b_c0", b_if.out_data, 8'h66);
    b_if.in_data = 8'h09;
    @(negedge clk);
    chk("b_c1_valid", b_if.out_valid, 1);
    chk("b_c1", b_if.out_data, 8'h65);
    @(negedge clk);
    chk("b_bubble_valid", b_if.out_valid, 0);
    chk("b_bubble_ready", b_if.in_ready, 1);
    @(negedge clk);
    b_if.in_valid = 1'b0;
    chk("b_c2_valid", b_if.out_valid, 1);
    chk("b_c2", b_if.out_data, 8'h30);
    @(negedge clk);
    chk("b_c3", b_if.out_data, 8'h39);
    @(negedge clk);
    chk("b_end_valid", b_if.out_valid, 0);
    chk("b_end_ready", b_if.in_ready, 1);
    @(negedge clk);
    chk("b_stays_idle", b_if.out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
